vend_sequencer: RTL
===================

# vend_sequencer

Transaction controller for the vending machine. Consumes one-cycle debounced key events and sequences product selection, quantity entry, price confirmation, coin accumulation, dispense handshake and change/refund. Drives the binary display value for the binary2bcd/seven_segment path and a state code for the status digits. Sits between the keypad/debounce front end and the dispenser/coin-return hardware.

## Interface
- TIMEOUT_CYCLES, default 50_000_000: inactivity limit (clk cycles) in SELECT..PAY before auto-cancel.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clock clk.
- key_valid  in  1  one-cycle strobe, debounced key event.
- key_code  in  4  key value, sampled when key_valid=1.
- vend_ack  in  1  dispenser completion, level, sampled while vend_req=1.
- vend_req  out  1  dispense request, held until vend_ack.
- change_valid  out  1  one-cycle pulse, change_amt valid and nonzero.
- change_amt  out  8  change/refund amount, binary.
- display_value  out  8  binary value for the main 3-digit display.
- state_code  out  3  current state encoding for the status display.
- busy  out  1  high in every state except IDLE.

## Operation
- States and encodings: IDLE=0, SELECT=1, PRICE=2, QTY=3, CONFIRM=4, PAY=5, VEND=6, CHANGE=7. state_code equals the current state.
- IDLE: key F -> SELECT; clears price, qty, total, paid.
- SELECT: key 1..5 latches price 15/12/10/5/2 -> PRICE.
- PRICE: key F -> QTY, qty loaded with 1.
- QTY: key 1..9 sets qty; key 0 ignored; key F -> CONFIRM, total <= price*qty (max 135, 8 bits, no overflow).
- CONFIRM: key E -> PAY, paid <= 0; key B -> SELECT.
- PAY: key 8/9/A adds 2/5/10 to paid. If paid+coin >= total, go to VEND on the same edge that paid updates.
- Cancel: key C in SELECT..PAY. If paid>0 -> CHANGE with change = paid (refund, no vend); otherwise -> IDLE.
- Timeout: a counter runs in SELECT..PAY. It reloads on any key_valid and on every state entry. When it reaches TIMEOUT_CYCLES, the block performs the cancel action. If key_valid and expiry occur on the same cycle, the key wins and the counter reloads.
- VEND: vend_req=1 from the first cycle; all keys ignored; no timeout. vend_ack sampled high -> CHANGE with change = paid-total; vend_req=0 on that same edge.
- CHANGE: lasts exactly 1 cycle. change_amt holds the change value; change_valid=1 only if change≠0. Then -> IDLE.
- Keys not listed for a state are ignored, with no state or register change.
- display_value by state: IDLE/SELECT 0; PRICE price; QTY qty; CONFIRM total; PAY paid; VEND total; CHANGE change.
- Max paid = total-1+10 ≤ 144, so the value fits 8 bits without saturation.

## Timing
- All outputs are registered and update on the clk edge following the causing key_valid.
- Reset (async, reset=0): state IDLE; vend_req, change_valid, busy, state_code, display_value, change_amt all 0; internal price, qty, total, paid and timeout counter cleared.
- Reset mid-operation (including VEND) drops vend_req immediately. Paid coins are lost; no refund pulse is issued.
- Latency: key strobe -> new state_code/display_value in 1 cycle. Final coin -> vend_req in 1 cycle. vend_ack -> change_valid in 1 cycle. change_valid -> IDLE in 1 cycle.
- vend_ack outside VEND is ignored. key_valid during VEND/CHANGE is dropped, not queued.

## Test plan
- Normal purchase with change: F,2,F,3,F,E, then A,A,A,8,9 → total 36; paid 10,20,30,32,37; VEND after the 9 key. Assert vend_ack 4 cycles later → change_valid pulse with change_amt=1, then state_code 0.
- Exact payment: F,5,F,F,E,8 → total 2, VEND. On ack, change_amt=0, change_valid stays 0, then IDLE.
- Cancel with refund: F,4,F,F,E,8,C → CHANGE with change_amt=2, change_valid=1 for one cycle; vend_req never asserted. Cancel in PRICE → IDLE with no pulse.
- Timeout (TIMEOUT_CYCLES=100): in PAY with paid=10, no keys for 100 cycles → refund change_amt=10. A key at cycle 99 reloads the counter and prevents the refund.
- Ignored keys: key 8 in PRICE and key 0 in QTY → display_value and state_code unchanged. Keys pressed during VEND have no effect.
- Reset during VEND with vend_req=1 → vend_req=0 and state_code=0 without a clock edge; the next F key starts a fresh SELECT.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending transaction controller: key-driven selection, quantity, payment,
// dispense handshake and change/refund, with an inactivity auto-cancel.
module vend_sequencer #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       vend_ack,
   output logic       vend_req,
   output logic       change_valid,
   output logic [7:0] change_amt,
   output logic [7:0] display_value,
   output logic [2:0] state_code,
   output logic       busy
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_PRICE   = 3'd2,
      S_QTY     = 3'd3,
      S_CONFIRM = 3'd4,
      S_PAY     = 3'd5,
      S_VEND    = 3'd6,
      S_CHANGE  = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       price_q, price_d;
   logic [3:0]       qty_q, qty_d;
   logic [7:0]       total_q, total_d;
   logic [7:0]       paid_q, paid_d;
   logic [7:0]       change_q, change_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vend_req_q, change_valid_q, busy_q;
   logic [7:0]       disp_q, disp_d;
   logic [2:0]       code_q;
   logic [7:0]       coin;
   logic [7:0]       pay_sum;
   logic             cancel;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         price_q        <= '0;
         qty_q          <= '0;
         total_q        <= '0;
         paid_q         <= '0;
         change_q       <= '0;
         cnt_q          <= '0;
         vend_req_q     <= 1'b0;
         change_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         disp_q         <= '0;
         code_q         <= '0;
      end else begin
         state_q        <= state_d;
         price_q        <= price_d;
         qty_q          <= qty_d;
         total_q        <= total_d;
         paid_q         <= paid_d;
         change_q       <= change_d;
         cnt_q          <= cnt_d;
         vend_req_q     <= (state_d == S_VEND);
         change_valid_q <= (state_d == S_CHANGE) && (change_d != 8'd0);
         busy_q         <= (state_d != S_IDLE);
         disp_q         <= disp_d;
         code_q         <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      price_d  = price_q;
      qty_d    = qty_q;
      total_d  = total_q;
      paid_d   = paid_q;
      change_d = change_q;
      cnt_d    = cnt_q;
      cancel   = 1'b0;
      coin     = 8'd0;
      case (key_code)
         4'h8:    coin = 8'd2;
         4'h9:    coin = 8'd5;
         4'hA:    coin = 8'd10;
         default: coin = 8'd0;
      endcase
      pay_sum = paid_q + coin;

      case (state_q)
         S_IDLE: begin
            if (key_valid && key_code == 4'hF) begin
               state_d = S_SELECT;
               price_d = '0;
               qty_d   = '0;
               total_d = '0;
               paid_d  = '0;
            end
         end
         S_SELECT: begin
            if (key_valid) begin
               state_d = S_PRICE;
               case (key_code)
                  4'h1:    price_d = 4'd15;
                  4'h2:    price_d = 4'd12;
                  4'h3:    price_d = 4'd10;
                  4'h4:    price_d = 4'd5;
                  4'h5:    price_d = 4'd2;
                  default: state_d = S_SELECT;
               endcase
               cancel = (key_code == 4'hC);
            end
         end
         S_PRICE: begin
            if (key_valid && key_code == 4'hF) begin
               state_d = S_QTY;
               qty_d   = 4'd1;
            end
            cancel = key_valid && (key_code == 4'hC);
         end
         S_QTY: begin
            if (key_valid && key_code >= 4'h1 && key_code <= 4'h9) begin
               qty_d = key_code;
            end else if (key_valid && key_code == 4'hF) begin
               state_d = S_CONFIRM;
               total_d = {4'd0, price_q} * {4'd0, qty_q};
            end
            cancel = key_valid && (key_code == 4'hC);
         end
         S_CONFIRM: begin
            if (key_valid && key_code == 4'hE) begin
               state_d = S_PAY;
               paid_d  = '0;
            end else if (key_valid && key_code == 4'hB) begin
               state_d = S_SELECT;
            end
            cancel = key_valid && (key_code == 4'hC);
         end
         S_PAY: begin
            if (key_valid && coin != 8'd0) begin
               paid_d = pay_sum;
               if (pay_sum >= total_q) state_d = S_VEND;
            end
            cancel = key_valid && (key_code == 4'hC);
         end
         S_VEND: begin
            if (vend_ack) begin
               state_d  = S_CHANGE;
               change_d = paid_q - total_q;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Inactivity timer: a key on the expiry cycle wins and reloads the count
      if (state_q inside {S_SELECT, S_PRICE, S_QTY, S_CONFIRM, S_PAY}) begin
         if (key_valid) begin
            cnt_d = '0;
         end else if (cnt_q == TMO_LAST) begin
            cancel = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end

      if (cancel) begin
         if (paid_q != 8'd0) begin
            state_d  = S_CHANGE;
            change_d = paid_q;
         end else begin
            state_d = S_IDLE;
         end
      end
      if (state_d != state_q) cnt_d = '0;

      case (state_d)
         S_PRICE:   disp_d = {4'd0, price_d};
         S_QTY:     disp_d = {4'd0, qty_d};
         S_CONFIRM: disp_d = total_d;
         S_PAY:     disp_d = paid_d;
         S_VEND:    disp_d = total_d;
         S_CHANGE:  disp_d = change_d;
         default:   disp_d = 8'd0;
      endcase
   end

   assign vend_req      = vend_req_q;
   assign change_valid  = change_valid_q;
   assign change_amt    = change_q;
   assign display_value = disp_q;
   assign state_code    = code_q;
   assign busy          = busy_q;

endmodule
